branch_ctrl: RTL
================

# branch_ctrl

Branch prediction and resolution controller for the skylark-v pipeline. It replaces the static predict-taken redirect logic with a parametrised table of saturating counters, indexed by PC. The block:
- predicts conditional branches in Decode,
- carries prediction metadata through an internal D→E register,
- resolves all six RV32I branch conditions from ALU flags in Execute,
- trains the table, and drives the fetch PC mux select plus pipeline flushes.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- BHT_ENTRIES, 16, counter table depth; power of two, ≥2
- CTR_W, 2, saturating counter width; ≥1

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- valid_D  in  1  Decode holds a real instruction
- op_D  in  7  opcode in Decode
- funct3_D  in  3  funct3 in Decode
- pc_D  in  XLEN  PC of Decode instruction
- stall_E  in  1  hold the D→E register (hazard unit)
- flush_E_in  in  1  external bubble insert into E (hazard unit)
- N, Z, C, V  in  1 each  ALU flags of E instruction (rs1−rs2)
- predict_taken_D  out  1  Decode instruction is redirected to its target
- PCSrc  out  2  00 PC+4; 01 target_D; 10 pc_E+4 (recover not-taken); 11 target_E (recover taken)
- flush_D  out  1  squash the Decode instruction
- flush_E  out  1  squash the D→E register input next edge

## Operation
- Decode classification: branch when op_D=1100011 and funct3_D ∈ {000,001,100,101,110,111}; jump when op_D=1101111. Branch with funct3 010/011 is treated as a non-branch: no prediction, no update.
- predict_taken_D: valid_D & (jump | branch & ctr[idx_D][CTR_W-1]), where idx = pc[log2(BHT_ENTRIES)+1:2].
- D→E register holds valid, is_branch, funct3, idx, predicted. Loaded every edge unless stall_E. Cleared (valid=0) when flush_E_in or flush_E is asserted. flush wins over stall.
- Execute condition: BEQ Z; BNE !Z; BLT N^V; BGE !(N^V); BLTU !C; BGEU C. C=1 means no borrow.
- Resolution occurs when E is valid & is_branch & !stall_E:
  - mispredict = taken ≠ predicted.
  - Taken increments the counter, saturating at 2^CTR_W−1. Not taken decrements it, saturating at 0.
- PCSrc priority:
  1. E mispredict: 11 if taken, else 10.
  2. Otherwise, predict_taken_D: 01.
  3. Otherwise: 00.
- Jumps never enter resolution; they are always correct.
- flush_D = E mispredict | predict_taken_D. flush_E = E mispredict.
- On E mispredict, predict_taken_D is forced 0 because the Decode instruction is wrong-path.

## Timing
- Reset values:
  - all counters = 2^(CTR_W−1) (weakly taken, matching legacy behaviour)
  - D→E valid = 0
  - PCSrc = 00, flush_D = 0, flush_E = 0, predict_taken_D = 0
- Reset mid-operation clears the E register immediately; outputs go to reset values without waiting for a clock edge.
- Prediction is combinational from registered table state, with zero latency in Decode.
- Resolution outputs are combinational in the E cycle. The counter update lands on the following edge.
- Same-index read in D and write from E in one cycle: D reads the old value; no bypass.
- stall_E with a valid branch in E: no update and no PCSrc 10/11 until the stall releases. Resolution occurs exactly once per branch.
- Back-to-back branches at the same index: the second sees the first's update only if it reaches D after the update edge.

## Configuration
- SKYLARK_BHT_EN defined: the counter table is instantiated as described above.
- Undefined: no table storage; every valid branch predicts taken (static); no update logic. Resolution, PCSrc and flush behaviour are otherwise identical. BHT_ENTRIES and CTR_W are ignored.

## Structure
- skylark_pkg holds:
  - OP_BRANCH and OP_JAL constants
  - funct3 enum (F3_BEQ…F3_BGEU)
  - pcsrc_t enum (PCSRC_PC4, PCSRC_TGT_D, PCSRC_REC_NT, PCSRC_REC_T)
  - the D→E metadata struct
- Sub-module branch_history_table: a counter array with one combinational read port, one synchronous saturating-update port, and async reset.

## Test plan
- Reset, then BEQ at pc_D=0x40 -> predict_taken_D=1, PCSrc=01, flush_D=1. In E with Z=0 -> PCSrc=10, flush_D=flush_E=1, and ctr[0] goes 2→1.
- Repeat the 0x40 BEQ not-taken twice more -> ctr goes 1→0 then stays 0. The next prediction is 0; with Z=1 in E -> PCSrc=11.
- BLTU with C=0 and BGE with N=1, V=1 -> both taken. BLT with N=1, V=1 -> not taken.
- Branch in E with stall_E=1 for 3 cycles -> PCSrc stays 00 and no counter change. After release, exactly one update and one redirect.
- Mispredict in E while a jump is in D -> PCSrc=10/11 (not 01) and predict_taken_D=0. Also assert reset mid-stall -> all outputs reset and counters = 2.
- SKYLARK_BHT_EN undefined -> every branch predicts taken regardless of history.

Source files
------------

// File: rtl/skylark_pkg.sv
// Shared opcode constants, branch funct3/PC-select encodings and Decode->Execute metadata for branch_ctrl.
package skylark_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } funct3_t;

    typedef enum logic [1:0] {
        PCSRC_PC4    = 2'b00,
        PCSRC_TGT_D  = 2'b01,
        PCSRC_REC_NT = 2'b10,
        PCSRC_REC_T  = 2'b11
    } pcsrc_t;

    typedef struct packed {
        logic       valid;
        logic       is_branch;
        logic [2:0] funct3;
        logic       predicted;
    } dx_meta_t;

    // funct3 010/011 under the branch opcode are reserved and handled as non-branches
    function automatic logic is_cond_branch(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_BRANCH) && (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    // Flags come from rs1-rs2; c=1 means no borrow (rs1 >= rs2 unsigned)
    function automatic logic branch_taken(input logic [2:0] f3, input logic n, input logic z,
                                          input logic c, input logic v);
        case (f3)
            F3_BEQ:  return z;
            F3_BNE:  return !z;
            F3_BLT:  return n ^ v;
            F3_BGE:  return !(n ^ v);
            F3_BLTU: return !c;
            F3_BGEU: return c;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Saturating-counter table: combinational read, one synchronous saturating update per cycle,
// every counter resets to weakly taken.
module branch_history_table #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx,
    output logic [CTR_W-1:0]           rd_ctr,
    input  logic                       upd_en,
    input  logic [$clog2(ENTRIES)-1:0] upd_idx,
    input  logic                       upd_taken
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = '1;

    logic [CTR_W-1:0] ctr_arr [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic [CTR_W-1:0] ctr_reg;
            logic [CTR_W-1:0] ctr_next;

            always_comb begin
                ctr_next = ctr_reg;
                if (upd_taken) begin
                    if (ctr_reg != CTR_MAX) ctr_next = ctr_reg + CTR_W'(1);
                end else begin
                    if (ctr_reg != '0) ctr_next = ctr_reg - CTR_W'(1);
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ctr_reg <= CTR_INIT;
                end else if (upd_en && (upd_idx == IDX_W'(gi))) begin
                    ctr_reg <= ctr_next;
                end
            end

            assign ctr_arr[gi] = ctr_reg;
        end
    endgenerate

    assign rd_ctr = ctr_arr[rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch predict/resolve controller: predicts in Decode, resolves in Execute, drives PCSrc and flushes.
// Define SKYLARK_BHT_EN for the dynamic counter table; otherwise every branch is statically predicted taken.
module branch_ctrl
    import skylark_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CTR_W       = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_D,
    input  logic [6:0]      op_D,
    input  logic [2:0]      funct3_D,
    input  logic [XLEN-1:0] pc_D,
    input  logic            stall_E,
    input  logic            flush_E_in,
    input  logic            N,
    input  logic            Z,
    input  logic            C,
    input  logic            V,
    output logic            predict_taken_D,
    output logic [1:0]      PCSrc,
    output logic            flush_D,
    output logic            flush_E
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    dx_meta_t e_reg;
    logic     is_branch_d;
    logic     is_jump_d;
    logic     pred_bit_d;
    logic     resolve_e;
    logic     taken_e;
    logic     mispredict_e;
    pcsrc_t   pcsrc_sel;
    logic     unused_bits;

    assign is_branch_d = valid_D & is_cond_branch(op_D, funct3_D);
    assign is_jump_d   = valid_D & (op_D == OP_JAL);

`ifdef SKYLARK_BHT_EN
    logic [IDX_W-1:0] idx_d;
    logic [IDX_W-1:0] idx_e_reg;
    logic [CTR_W-1:0] ctr_d;

    assign idx_d = pc_D[IDX_W+1:2];

    branch_history_table #(
        .ENTRIES (BHT_ENTRIES),
        .CTR_W   (CTR_W)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (idx_d),
        .rd_ctr    (ctr_d),
        .upd_en    (resolve_e),
        .upd_idx   (idx_e_reg),
        .upd_taken (taken_e)
    );

    assign pred_bit_d  = ctr_d[CTR_W-1];
    assign unused_bits = ^{pc_D, ctr_d};

    // Index only matters alongside a valid E entry, so it simply follows the stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_e_reg <= '0;
        end else if (!stall_E) begin
            idx_e_reg <= idx_d;
        end
    end
`else
    assign pred_bit_d  = 1'b1;
    assign unused_bits = ^pc_D;
`endif

    // Flush beats stall: a squashed E slot must not survive a held pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_reg <= '0;
        end else if (flush_E_in || flush_E) begin
            e_reg <= '0;
        end else if (!stall_E) begin
            e_reg.valid     <= valid_D;
            e_reg.is_branch <= is_branch_d;
            e_reg.funct3    <= funct3_D;
            e_reg.predicted <= pred_bit_d;
        end
    end

    assign resolve_e    = e_reg.valid & e_reg.is_branch & ~stall_E;
    assign taken_e      = branch_taken(e_reg.funct3, N, Z, C, V);
    assign mispredict_e = resolve_e & (taken_e != e_reg.predicted);

    // A mispredict in E means the Decode slot is wrong-path, so it never redirects
    assign predict_taken_D = ~reset & ~mispredict_e & (is_jump_d | (is_branch_d & pred_bit_d));

    always_comb begin
        pcsrc_sel = PCSRC_PC4;
        if (mispredict_e) begin
            pcsrc_sel = taken_e ? PCSRC_REC_T : PCSRC_REC_NT;
        end else if (predict_taken_D) begin
            pcsrc_sel = PCSRC_TGT_D;
        end
    end

    assign PCSrc   = pcsrc_sel;
    assign flush_D = mispredict_e | predict_taken_D;
    assign flush_E = mispredict_e;

endmodule
